// File: rtl/sdram_arbmod_if.sv
// Channel A, channel B and sdram_basemod-side signals of the two-port
// SDRAM arbiter, bundled so that the arbiter and its environment connect
// through a single port.
//   slave  : the arbiter's view (serves both channels, drives the SDRAM side)
//   master : the environment's view (requesters plus the sdram_basemod instance)
interface sdram_arbmod_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  // Channel A: [1]=write, [0]=read
  logic [1:0]        A_iCall;
  logic [1:0]        A_oDone;
  logic [ADDR_W-1:0] A_iAddr;
  logic [DATA_W-1:0] A_iData;
  logic [DATA_W-1:0] A_oData;
  // Channel B
  logic [1:0]        B_iCall;
  logic [1:0]        B_oDone;
  logic [ADDR_W-1:0] B_iAddr;
  logic [DATA_W-1:0] B_iData;
  logic [DATA_W-1:0] B_oData;
  // Toward sdram_basemod
  logic [1:0]        M_oCall;
  logic [1:0]        M_iDone;
  logic [ADDR_W-1:0] M_oAddr;
  logic [DATA_W-1:0] M_oData;
  logic [DATA_W-1:0] M_iData;
  // Status
  logic [1:0]        oGrant;
  logic              oBusy;

  modport slave (
    input  A_iCall, A_iAddr, A_iData,
    output A_oDone, A_oData,
    input  B_iCall, B_iAddr, B_iData,
    output B_oDone, B_oData,
    output M_oCall, M_oAddr, M_oData,
    input  M_iDone, M_iData,
    output oGrant, oBusy
  );

  modport master (
    output A_iCall, A_iAddr, A_iData,
    input  A_oDone, A_oData,
    output B_iCall, B_iAddr, B_iData,
    input  B_oDone, B_oData,
    input  M_oCall, M_oAddr, M_oData,
    output M_iDone, M_iData,
    input  oGrant, oBusy
  );
endinterface

// File: rtl/sdram_arbmod.sv
// Two-port arbiter in front of one sdram_basemod. Grants one single-word
// transaction at a time; a write pending on a channel goes before its read;
// ties between channels alternate using the record of the last grant.
// Every output comes straight from a register.
module sdram_arbmod #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input logic           CLOCK,
  input logic           RESET,
  sdram_arbmod_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETURN = 2'd2
  } state_t;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  state_t            r_state,   w_state_next;
  logic [1:0]        r_m_call,  w_m_call_next;
  logic [ADDR_W-1:0] r_m_addr,  w_m_addr_next;
  logic [DATA_W-1:0] r_m_data,  w_m_data_next;
  logic              r_op_wr,   w_op_wr_next;
  logic [1:0]        r_grant,   w_grant_next;
  logic              r_last,    w_last_next;
  logic              r_busy,    w_busy_next;
  logic [1:0]        r_a_done,  w_a_done_next;
  logic [1:0]        r_b_done,  w_b_done_next;
  logic [DATA_W-1:0] r_a_data,  w_a_data_next;
  logic [DATA_W-1:0] r_b_data,  w_b_data_next;

  logic              w_a_req;
  logic              w_b_req;
  logic              w_pick_b;
  logic              w_pick_wr;
  logic [1:0]        w_op_bit;

  // Next-state and next-output decode for the IDLE/ISSUE/RETURN sequence
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next  = r_state;
    w_m_call_next = r_m_call;
    w_m_addr_next = r_m_addr;
    w_m_data_next = r_m_data;
    w_op_wr_next  = r_op_wr;
    w_grant_next  = r_grant;
    w_last_next   = r_last;
    w_a_done_next = 2'b00;
    w_b_done_next = 2'b00;
    w_a_data_next = r_a_data;
    w_b_data_next = r_b_data;

    w_a_req   = |bus.A_iCall;
    w_b_req   = |bus.B_iCall;
    // B wins when it is alone, or on a tie when A was served last
    w_pick_b  = w_b_req && (!w_a_req || (r_last == LAST_A));
    // A write pending on the chosen channel goes ahead of its read
    w_pick_wr = w_pick_b ? bus.B_iCall[1] : bus.A_iCall[1];
    w_op_bit  = r_op_wr ? 2'b10 : 2'b01;

    unique case (r_state)
      IDLE: begin
        if (w_a_req || w_b_req) begin
          w_op_wr_next  = w_pick_wr;
          w_m_call_next = w_pick_wr ? 2'b10 : 2'b01;
          w_m_addr_next = w_pick_b ? bus.B_iAddr : bus.A_iAddr;
          w_m_data_next = w_pick_b ? bus.B_iData : bus.A_iData;
          w_grant_next  = w_pick_b ? 2'b10 : 2'b01;
          w_last_next   = w_pick_b ? LAST_B : LAST_A;
          w_state_next  = ISSUE;
        end
      end
      ISSUE: begin
        // Only a done on the op's own bit ends the transaction
        if ((bus.M_iDone & w_op_bit) != 2'b00) begin
          w_m_call_next = 2'b00;
          if (r_grant[1]) begin
            w_b_done_next = w_op_bit;
            if (!r_op_wr) w_b_data_next = bus.M_iData;
          end else begin
            w_a_done_next = w_op_bit;
            if (!r_op_wr) w_a_data_next = bus.M_iData;
          end
          w_state_next = RETURN;
        end
      end
      RETURN: begin
        w_grant_next = 2'b00;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_busy_next = (w_state_next != IDLE);
  end

  // FSM state register
  always_ff @(posedge CLOCK or negedge RESET) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_m_call <= 2'b00;
      r_m_addr <= '0;
      r_m_data <= '0;
      r_op_wr  <= 1'b0;
      r_grant  <= 2'b00;
      r_last   <= LAST_B;
      r_busy   <= 1'b0;
      r_a_done <= 2'b00;
      r_b_done <= 2'b00;
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      r_m_call <= w_m_call_next;
      r_m_addr <= w_m_addr_next;
      r_m_data <= w_m_data_next;
      r_op_wr  <= w_op_wr_next;
      r_grant  <= w_grant_next;
      r_last   <= w_last_next;
      r_busy   <= w_busy_next;
      r_a_done <= w_a_done_next;
      r_b_done <= w_b_done_next;
      r_a_data <= w_a_data_next;
      r_b_data <= w_b_data_next;
    end
  end

  assign bus.M_oCall = r_m_call;
  assign bus.M_oAddr = r_m_addr;
  assign bus.M_oData = r_m_data;
  assign bus.oGrant  = r_grant;
  assign bus.oBusy   = r_busy;
  assign bus.A_oDone = r_a_done;
  assign bus.A_oData = r_a_data;
  assign bus.B_oDone = r_b_done;
  assign bus.B_oData = r_b_data;

endmodule
